exec_wb_datapath: RTL and testbench
===================================

# exec_wb_datapath

Execute/write-back slice of the single-cycle RV32 core: selects the ALU B operand, performs the integer operation and selects the register-file write-back value. It sits between the register bank / immediate generators and the register-bank write port. All datapath outputs are combinational. A small reset-cleared status register holds the last ALU result and zero flag for debug and bench observation.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- s_mux_b  in  2  B-operand select.
- s_mux_c  in  2  write-back select.
- alu_ctrl  in  2  ALU operation; driven by funct7[6:5].
- doa  in  32  rs1 read data (ALU A operand).
- dob  in  32  rs2 read data.
- imm_ex  in  32  sign-extended I-type immediate.
- imm_sw  in  32  sign-extended S-type immediate (imm[11:5]‖imm[4:0]).
- instr  in  32  current instruction word.
- mem_out  in  32  data-memory read data.
- b_op  out  32  selected B operand.
- alu_out  out  32  ALU result.
- zero  out  1  1 when alu_out == 0.
- wb_data  out  32  register-file write data (DI).
- alu_out_q  out  32  registered alu_out.
- zero_q  out  1  registered zero.

## Operation
- B mux: 00 → dob; 01 → imm_ex; 10 → imm_sw; 11 → dob.
- ALU ops:
  - 00: doa + b_op.
  - 01: doa − b_op.
  - 10: doa & b_op.
  - 11: doa | b_op.
- Arithmetic is modulo 2^32: carry and overflow are discarded, and no flags other than zero exist.
- zero = (alu_out == 32'h0) for every op.
- lw/sw with small positive offsets present alu_ctrl = 00, so they compute the address as base + offset.
- Write-back mux:
  - 00 → alu_out.
  - 01 → mem_out.
  - 10 → {instr[31:12], 12'h000} (LUI value).
  - 11 → alu_out.
- No X propagation from unselected inputs. Outputs depend only on the selected sources.

## Timing
- b_op, alu_out, zero and wb_data are purely combinational, with zero-cycle latency. The register bank captures wb_data on the same rising edge that ends the instruction.
- Status register, at each rising clk:
  - if rst_n = 0: alu_out_q ← 0 and zero_q ← 0.
  - otherwise: alu_out_q ← alu_out and zero_q ← zero.
- Reset values: alu_out_q = 32'h0 and zero_q = 0.
- Reset deassertion is seen only at a clock edge. The first capture happens on the first edge with rst_n = 1.
- Reset never affects the combinational outputs.
- Reset asserted mid-operation clears only the status register, at the next edge.
- No handshake: a new operation is accepted every cycle.

## Structure
- Shared package core_pkg holds:
  - typedefs for the 2-bit s_mux_b encoding (SEL_B_RS2, SEL_B_IMM_I, SEL_B_IMM_S);
  - typedefs for the 2-bit s_mux_c encoding (SEL_WB_ALU, SEL_WB_MEM, SEL_WB_LUI);
  - an alu_op_t enum (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR);
  - XLEN.
- The same package is used by the control unit.
- One sub-module, alu_core: combinational adder/subtractor, logic ops and zero detect.
- Both muxes and the status register stay in the top level.

## Test plan
- R-type add: doa = 5, dob = 7, s_mux_b = 00, alu_ctrl = 00, s_mux_c = 00 → b_op = 7, alu_out = 12, zero = 0, wb_data = 12.
- Sub to zero and wrap:
  - doa = 9, dob = 9, alu_ctrl = 01 → alu_out = 0, zero = 1.
  - doa = 0, dob = 1, alu_ctrl = 01 → alu_out = 32'hFFFF_FFFF, zero = 0.
  - doa = 32'hFFFF_FFFF, b_op = 1, add → alu_out = 0, zero = 1.
- Load: doa = 32'h100, imm_ex = 32'hFFFF_FFFC, s_mux_b = 01, alu_ctrl = 00, mem_out = 32'hDEAD_BEEF, s_mux_c = 01 → alu_out = 32'h0FC, wb_data = 32'hDEAD_BEEF.
- Store: doa = 32'h20, imm_sw = 8, s_mux_b = 10, add → alu_out = 32'h28, and b_op ignores dob.
- LUI and logic ops:
  - instr = 32'h12345_0B7, s_mux_c = 10 → wb_data = 32'h1234_5000.
  - doa = 32'hF0F0, b_op = 32'h0FF0:
    - AND → 32'h00F0;
    - OR → 32'hFFF0.
- Reset/status:
  - hold rst_n = 0 for 2 edges with alu_out = 12 → alu_out_q = 0, zero_q = 0;
  - release → the next edge captures 12;
  - assert rst_n = 0 mid-sequence → cleared at the following edge, while alu_out is unaffected.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the RV32 core: operand/write-back selects and ALU opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

    // Datapath width; the core is RV32 only.
    localparam int XLEN = 32;

    // B-operand select; code 2'b11 is unused and falls back to rs2.
    typedef enum logic [1:0] {
        SEL_B_RS2   = 2'b00,
        SEL_B_IMM_I = 2'b01,
        SEL_B_IMM_S = 2'b10
    } sel_b_t;

    // Write-back select; code 2'b11 is unused and falls back to the ALU result.
    typedef enum logic [1:0] {
        SEL_WB_ALU = 2'b00,
        SEL_WB_MEM = 2'b01,
        SEL_WB_LUI = 2'b10
    } sel_wb_t;

    // ALU operation, taken straight from funct7[6:5].
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

endpackage

// File: rtl/alu_core.sv
// Integer ALU: add/sub (modulo 2^XLEN, no carry/overflow), and/or, zero detect.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result is valid whenever inputs are.
module alu_core #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    input  core_pkg::alu_op_t   op_i,
    output logic [XLEN-1:0]     y_o,
    output logic                zero_o
);

    import core_pkg::*;

    // Operation select; every encoding is defined so no state is held.
    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            default: y_o = '0;
        endcase
    end

    // Zero flag is defined for every operation, not just subtract.
    always_comb begin
        zero_o = (y_o == '0);
    end

endmodule

// File: rtl/exec_wb_datapath.sv
// Execute/write-back slice: B-operand mux, ALU, write-back mux, debug status register.
// Latency: b_op/alu_out/zero/wb_data combinational; alu_out_q/zero_q one clock later.
// Backpressure: none; a new operation is accepted every cycle.
module exec_wb_datapath #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      s_mux_b,
    input  logic [1:0]      s_mux_c,
    input  logic [1:0]      alu_ctrl,
    input  logic [XLEN-1:0] doa,
    input  logic [XLEN-1:0] dob,
    input  logic [XLEN-1:0] imm_ex,
    input  logic [XLEN-1:0] imm_sw,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] mem_out,
    output logic [XLEN-1:0] b_op,
    output logic [XLEN-1:0] alu_out,
    output logic            zero,
    output logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] alu_out_q,
    output logic            zero_q
);

    import core_pkg::*;

    alu_op_t alu_op;

    // funct7[6:5] maps one-to-one onto the ALU opcode; all four codes are legal.
    always_comb begin
        alu_op = alu_op_t'(alu_ctrl);
    end

    // B-operand select; the spare code reuses rs2 so no unselected input leaks through.
    always_comb begin
        b_op = dob;
        case (s_mux_b)
            SEL_B_RS2:   b_op = dob;
            SEL_B_IMM_I: b_op = imm_ex;
            SEL_B_IMM_S: b_op = imm_sw;
            default:     b_op = dob;
        endcase
    end

    alu_core #(
        .XLEN (XLEN)
    ) u_alu (
        .a_i    (doa),
        .b_i    (b_op),
        .op_i   (alu_op),
        .y_o    (alu_out),
        .zero_o (zero)
    );

    // Write-back select; LUI places instr[31:12] in the upper bits with a zero low 12 bits.
    always_comb begin
        wb_data = alu_out;
        case (s_mux_c)
            SEL_WB_ALU: wb_data = alu_out;
            SEL_WB_MEM: wb_data = mem_out;
            SEL_WB_LUI: wb_data = {instr[XLEN-1:12], 12'h000};
            default:    wb_data = alu_out;
        endcase
    end

    // Debug status: last ALU result and zero flag, cleared synchronously by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_out_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            alu_out_q <= alu_out;
            zero_q    <= zero;
        end
    end

endmodule

// File: tb/tb_exec_wb_datapath.sv
// Directed bench for exec_wb_datapath: table-driven combinational vectors plus status-register sequences.
// Latency: comb outputs sampled 2 ns after input change; status sampled 1 ns after the capturing edge.
// Backpressure: none.
module tb_exec_wb_datapath;

    logic        clk;
    logic        rst_n;
    logic [1:0]  s_mux_b;
    logic [1:0]  s_mux_c;
    logic [1:0]  alu_ctrl;
    logic [31:0] doa;
    logic [31:0] dob;
    logic [31:0] imm_ex;
    logic [31:0] imm_sw;
    logic [31:0] instr;
    logic [31:0] mem_out;
    logic [31:0] b_op;
    logic [31:0] alu_out;
    logic        zero;
    logic [31:0] wb_data;
    logic [31:0] alu_out_q;
    logic        zero_q;

    int n_cmp;
    int n_fail;

    exec_wb_datapath #(
        .XLEN (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_mux_b   (s_mux_b),
        .s_mux_c   (s_mux_c),
        .alu_ctrl  (alu_ctrl),
        .doa       (doa),
        .dob       (dob),
        .imm_ex    (imm_ex),
        .imm_sw    (imm_sw),
        .instr     (instr),
        .mem_out   (mem_out),
        .b_op      (b_op),
        .alu_out   (alu_out),
        .zero      (zero),
        .wb_data   (wb_data),
        .alu_out_q (alu_out_q),
        .zero_q    (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  mb;
        logic [1:0]  mc;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ie;
        logic [31:0] is;
        logic [31:0] ins;
        logic [31:0] mem;
        logic [31:0] exp_b;
        logic [31:0] exp_alu;
        logic        exp_z;
        logic [31:0] exp_wb;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        s_mux_b  = v.mb;
        s_mux_c  = v.mc;
        alu_ctrl = v.op;
        doa      = v.a;
        dob      = v.b;
        imm_ex   = v.ie;
        imm_sw   = v.is;
        instr    = v.ins;
        mem_out  = v.mem;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        //          name        mb     mc     op     doa           dob           imm_ex        imm_sw        instr         mem_out       exp_b         exp_alu       z     exp_wb
        vecs[0]  = '{"add",     2'b00, 2'b00, 2'b00, 32'h5,        32'h7,        32'hAAAA,     32'hBBBB,     32'hFFFFF000, 32'hCCCC,     32'h7,        32'hC,        1'b0, 32'hC};
        vecs[1]  = '{"sub0",    2'b00, 2'b00, 2'b01, 32'h9,        32'h9,        32'h1,        32'h2,        32'h0,        32'h3,        32'h9,        32'h0,        1'b1, 32'h0};
        vecs[2]  = '{"subwrap", 2'b00, 2'b00, 2'b01, 32'h0,        32'h1,        32'h0,        32'h0,        32'h0,        32'h0,        32'h1,        32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF};
        vecs[3]  = '{"addwrap", 2'b00, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1,        32'h5,        32'h6,        32'h0,        32'h7,        32'h1,        32'h0,        1'b1, 32'h0};
        vecs[4]  = '{"load",    2'b01, 2'b01, 2'b00, 32'h100,      32'h55,       32'hFFFFFFFC, 32'h77,       32'h0,        32'hDEADBEEF, 32'hFFFFFFFC, 32'hFC,       1'b0, 32'hDEADBEEF};
        vecs[5]  = '{"store",   2'b10, 2'b00, 2'b00, 32'h20,       32'h12345,    32'h40,       32'h8,        32'h0,        32'h99,       32'h8,        32'h28,       1'b0, 32'h28};
        vecs[6]  = '{"lui",     2'b00, 2'b10, 2'b00, 32'h0,        32'h0,        32'h3,        32'h4,        32'h123450B7, 32'h5,        32'h0,        32'h0,        1'b1, 32'h12345000};
        vecs[7]  = '{"and",     2'b00, 2'b00, 2'b10, 32'hF0F0,     32'h0FF0,     32'h0,        32'h0,        32'h0,        32'h0,        32'h0FF0,     32'h00F0,     1'b0, 32'h00F0};
        vecs[8]  = '{"or",      2'b00, 2'b00, 2'b11, 32'hF0F0,     32'h0FF0,     32'h0,        32'h0,        32'h0,        32'h0,        32'h0FF0,     32'hFFF0,     1'b0, 32'hFFF0};
        vecs[9]  = '{"spare",   2'b11, 2'b11, 2'b00, 32'h1,        32'h2,        32'h100,      32'h200,      32'hABCDE000, 32'h300,      32'h2,        32'h3,        1'b0, 32'h3};
        vecs[10] = '{"andzero", 2'b00, 2'b00, 2'b10, 32'hF0,       32'h0F,       32'hFF,       32'hFF,       32'h0,        32'h0,        32'h0F,       32'h0,        1'b1, 32'h0};

        // Reset held for two edges with alu_out = 12.
        rst_n = 1'b0;
        drive(vecs[0]);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_alu_q", alu_out_q, 32'h0);
        chk("rst_zero_q", {31'h0, zero_q}, 32'h0);
        chk("rst_alu_comb", alu_out, 32'hC);

        // Release: first edge with rst_n high captures 12.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_pre_alu_q", alu_out_q, 32'h0);
        @(posedge clk);
        #1;
        chk("rel_alu_q", alu_out_q, 32'hC);
        chk("rel_zero_q", {31'h0, zero_q}, 32'h0);

        // Capture a zero result.
        @(negedge clk);
        drive(vecs[1]);
        @(posedge clk);
        #1;
        chk("cap_alu_q", alu_out_q, 32'h0);
        chk("cap_zero_q", {31'h0, zero_q}, 32'h1);

        // Mid-sequence reset: holds until the edge, then clears; comb path unaffected.
        @(negedge clk);
        drive(vecs[0]);
        rst_n = 1'b0;
        #1;
        chk("mid_pre_zero_q", {31'h0, zero_q}, 32'h1);
        @(posedge clk);
        #1;
        chk("mid_alu_q", alu_out_q, 32'h0);
        chk("mid_zero_q", {31'h0, zero_q}, 32'h0);
        chk("mid_alu_comb", alu_out, 32'hC);
        chk("mid_wb_comb", wb_data, 32'hC);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors: combinational checks, then the status capture of the same vector.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            chk({vecs[i].name, "_b_op"}, b_op, vecs[i].exp_b);
            chk({vecs[i].name, "_alu"}, alu_out, vecs[i].exp_alu);
            chk({vecs[i].name, "_zero"}, {31'h0, zero}, {31'h0, vecs[i].exp_z});
            chk({vecs[i].name, "_wb"}, wb_data, vecs[i].exp_wb);
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_alu_q"}, alu_out_q, vecs[i].exp_alu);
            chk({vecs[i].name, "_zero_q"}, {31'h0, zero_q}, {31'h0, vecs[i].exp_z});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
